// File: rtl/cache_fill_fsm.sv
// Cache-miss fill controller: fetches one block as BLOCK_WORDS pipelined word reads and streams them into the data array.
// Optional feature: define CRITICAL_WORD_FIRST_EN to request and write the missing word first, wrapping within the block.
module cache_fill_fsm #(
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_W      = 16,
    localparam int OFF_W      = $clog2(BLOCK_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              mem_en,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [OFF_W-1:0]  word_offset,
    output logic              write_tag_array,
    output logic              fill_done
);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    localparam logic [OFF_W:0]    CNT_FULL  = (OFF_W+1)'(BLOCK_WORDS);
    localparam logic [OFF_W:0]    CNT_LAST  = (OFF_W+1)'(BLOCK_WORDS - 1);
    localparam logic [OFF_W:0]    CNT_ONE   = (OFF_W+1)'(1);
    // Clears the word offset and the byte-in-word bit, leaving the block base.
    localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << (OFF_W + 1);

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_base;
    logic [OFF_W-1:0]  r_startOff;
    logic [OFF_W:0]    r_issueCnt;
    logic [OFF_W:0]    r_recvCnt;
    logic [OFF_W-1:0]  w_issueOff;
    logic [OFF_W-1:0]  w_recvOff;

    assign w_issueOff = r_startOff + r_issueCnt[OFF_W-1:0];
    assign w_recvOff  = r_startOff + r_recvCnt[OFF_W-1:0];
    assign fsm_busy   = (r_state == FILL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_startOff <= '0;
            r_issueCnt <= '0;
            r_recvCnt  <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == IDLE) begin
                if (miss_detected) begin
                    r_base     <= miss_address & BASE_MASK;
`ifdef CRITICAL_WORD_FIRST_EN
                    r_startOff <= miss_address[OFF_W:1];
`else
                    r_startOff <= '0;
`endif
                    r_issueCnt <= '0;
                    r_recvCnt  <= '0;
                end
            end else begin
                if (mem_en) begin
                    r_issueCnt <= r_issueCnt + CNT_ONE;
                end
                if (write_data_array) begin
                    r_recvCnt <= r_recvCnt + CNT_ONE;
                end
            end
        end
    end

    // Issue and receive sides run independently; only the count of returned words ends the fill.
    always_comb begin
        w_nextState      = r_state;
        mem_en           = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        word_offset      = '0;
        write_tag_array  = 1'b0;
        fill_done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (miss_detected) begin
                    w_nextState = FILL;
                end
            end
            FILL: begin
                if (r_issueCnt < CNT_FULL) begin
                    mem_en         = 1'b1;
                    memory_address = r_base | (ADDR_W'(w_issueOff) << 1);
                end
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    word_offset      = w_recvOff;
                    if (r_recvCnt == CNT_LAST) begin
                        write_tag_array = 1'b1;
                        fill_done       = 1'b1;
                        w_nextState     = IDLE;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

endmodule
